mem_ctrl: RTL and testbench

MEM_CTRL -- requirements
Module: mem_ctrl

---
 rtl/mem_ctrl_if.sv | 54 +++++
 rtl/mem_ctrl.sv | 167 ++++++++++++++++
 tb/tb_mem_ctrl.sv | 289 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_ctrl_if.sv
// -----------------------------------------------------------------------------
// mem_ctrl_if -- bus bundle between mem_ctrl and its environment.
//
// Carries the client request/response handshake, the memory-side strobes and
// data, and the fill-engine control pair.
//
// Modports:
//   slave  : the controller (accepts requests, drives the memory pins)
//   master : the environment (client issuing requests plus the memory device
//            returning mem_rdata)
//
// Parameters:
//   ADDR_SIZE : memory address width
//   DATA_SIZE : memory data width
// -----------------------------------------------------------------------------
interface mem_ctrl_if #(
  parameter int ADDR_SIZE = 10,
  parameter int DATA_SIZE = 8
);

  // Client request / response
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_wr;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [DATA_SIZE-1:0] req_wdata;
  logic                 rsp_valid;
  logic [DATA_SIZE-1:0] rsp_rdata;

  // Memory device pins
  logic [ADDR_SIZE-1:0] mem_addr;
  logic                 mem_cs;
  logic                 mem_rd;
  logic                 mem_wt;
  logic [DATA_SIZE-1:0] mem_wdata;
  logic [DATA_SIZE-1:0] mem_rdata;

  // Fill engine
  logic                 fill_start;
  logic                 fill_busy;

  modport slave (
    input  req_valid, req_wr, req_addr, req_wdata, mem_rdata, fill_start,
    output req_ready, rsp_valid, rsp_rdata,
    output mem_addr, mem_cs, mem_rd, mem_wt, mem_wdata, fill_busy
  );

  modport master (
    output req_valid, req_wr, req_addr, req_wdata, mem_rdata, fill_start,
    input  req_ready, rsp_valid, rsp_rdata,
    input  mem_addr, mem_cs, mem_rd, mem_wt, mem_wdata, fill_busy
  );

endinterface

// File: rtl/mem_ctrl.sv
// -----------------------------------------------------------------------------
// mem_ctrl -- fixed-latency SRAM-style memory controller.
//
// Every access (client read, client write, fill write) runs the same
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD -> IDLE sequence. With the
// request accepted in cycle 0, rsp_valid pulses in cycle 2+WAIT_CYCLES and the
// next request can be accepted in cycle 3+WAIT_CYCLES. All outputs are
// registered.
//
// Optional feature: define MEM_CTRL_FILL_EN to build the fill engine, which
// writes (2*addr) mod 2^DATA_SIZE to every address 0..MEMORY_SIZE-1 after a
// fill_start pulse. Without it, fill_start is ignored and fill_busy is 0.
//
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : mem_ctrl_if.slave -- request/response, memory pins, fill control
//
// Parameters:
//   ADDR_SIZE   : address width (default 10)
//   DATA_SIZE   : data width (default 8)
//   MEMORY_SIZE : number of words covered by the fill engine (default 1024)
//   WAIT_CYCLES : cycles spent in ACCESS, legal range 1..15 (default 1)
// -----------------------------------------------------------------------------
module mem_ctrl #(
  parameter int ADDR_SIZE   = 10,
  parameter int DATA_SIZE   = 8,
  parameter int MEMORY_SIZE = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  mem_ctrl_if.slave bus
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  localparam logic [3:0]           WAIT_LAST = 4'(WAIT_CYCLES - 1);
  localparam logic [ADDR_SIZE-1:0] FILL_LAST = ADDR_SIZE'(MEMORY_SIZE - 1);

  state_t               state;
  logic [3:0]           wait_cnt;
  logic                 wr_q;        // current access is a write
  logic                 fill_q;      // current access belongs to the fill engine
  logic                 fill_busy_q;
  logic [ADDR_SIZE-1:0] fill_addr;

  logic                 req_ready_q;
  logic                 rsp_valid_q;
  logic [DATA_SIZE-1:0] rsp_rdata_q;
  logic [ADDR_SIZE-1:0] mem_addr_q;
  logic                 mem_cs_q;
  logic                 mem_rd_q;
  logic                 mem_wt_q;
  logic [DATA_SIZE-1:0] mem_wdata_q;

`ifdef MEM_CTRL_FILL_EN
  localparam bit FILL_EN = 1'b1;
  assign bus.fill_busy = fill_busy_q;
`else
  localparam bit FILL_EN = 1'b0;
  assign bus.fill_busy = 1'b0;
`endif

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_cs    = mem_cs_q;
  assign bus.mem_rd    = mem_rd_q;
  assign bus.mem_wt    = mem_wt_q;
  assign bus.mem_wdata = mem_wdata_q;

  // NOTE: the asynchronous reset branch is what makes mem_cs and the strobes
  // drop the instant rst_n falls, abandoning any access in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      wr_q        <= 1'b0;
      fill_q      <= 1'b0;
      fill_busy_q <= 1'b0;
      fill_addr   <= '0;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      mem_addr_q  <= '0;
      mem_cs_q    <= 1'b0;
      mem_rd_q    <= 1'b0;
      mem_wt_q    <= 1'b0;
      mem_wdata_q <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge values of state and the output registers.
      case (state)
        IDLE: begin
          if (fill_busy_q) begin
            // Launch the next fill write; the address register doubles as the
            // source of the data pattern.
            state       <= SETUP;
            mem_cs_q    <= 1'b1;
            mem_addr_q  <= fill_addr;
            mem_wdata_q <= DATA_SIZE'({fill_addr, 1'b0});
            wr_q        <= 1'b1;
            fill_q      <= 1'b1;
            wait_cnt    <= WAIT_LAST;
          end else if (bus.req_valid && req_ready_q) begin
            state       <= SETUP;
            mem_cs_q    <= 1'b1;
            mem_addr_q  <= bus.req_addr;
            mem_wdata_q <= bus.req_wdata;
            wr_q        <= bus.req_wr;
            fill_q      <= 1'b0;
            wait_cnt    <= WAIT_LAST;
            req_ready_q <= 1'b0;
          end else if (FILL_EN && bus.fill_start && !bus.req_valid) begin
            // Spend this IDLE cycle arming the engine so each fill write,
            // including the first, occupies a full 3+WAIT_CYCLES slot.
            fill_busy_q <= 1'b1;
            req_ready_q <= 1'b0;
          end else begin
            // Also covers the first cycle out of reset.
            req_ready_q <= 1'b1;
          end
        end

        SETUP: begin
          state    <= ACCESS;
          mem_rd_q <= !wr_q;
          mem_wt_q <= wr_q;
        end

        ACCESS: begin
          if (wait_cnt == 4'd0) begin
            state       <= HOLD;
            mem_rd_q    <= 1'b0;
            mem_wt_q    <= 1'b0;
            rsp_valid_q <= !fill_q;
            if (!wr_q) rsp_rdata_q <= bus.mem_rdata;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end

        HOLD: begin
          state       <= IDLE;
          mem_cs_q    <= 1'b0;
          rsp_valid_q <= 1'b0;
          if (fill_q) begin
            if (fill_addr == FILL_LAST) begin
              fill_addr   <= '0;
              fill_busy_q <= 1'b0;
              req_ready_q <= 1'b1;
            end else begin
              fill_addr <= fill_addr + ADDR_SIZE'(1);
            end
          end else begin
            req_ready_q <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_ctrl -- self-checking bench for mem_ctrl.
//
// dut  : WAIT_CYCLES=1, backed by a 1024-word memory model.
// dut3 : WAIT_CYCLES=3, memory model returns 8'hA5 at address 5.
// Fill-engine expectations follow the MEM_CTRL_FILL_EN macro.
// -----------------------------------------------------------------------------
module tb_mem_ctrl;

  localparam int AW = 10;
  localparam int DW = 8;
  localparam int W  = 1;
  localparam int W3 = 3;

  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [DW-1:0] rdata;   // rsp_rdata expected in HOLD (held value for writes)
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  mem_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus ();
  mem_ctrl_if #(.ADDR_SIZE(AW), .DATA_SIZE(DW)) bus3 ();

  mem_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEMORY_SIZE(1024), .WAIT_CYCLES(W))
    dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  mem_ctrl #(.ADDR_SIZE(AW), .DATA_SIZE(DW), .MEMORY_SIZE(1024), .WAIT_CYCLES(W3))
    dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Memory models
  logic [DW-1:0] mem [1024];
  assign bus.mem_rdata  = mem[bus.mem_addr];
  assign bus3.mem_rdata = (bus3.mem_addr == 10'd5) ? 8'hA5 : 8'h00;

  always @(posedge clk)
    if (bus.mem_cs && bus.mem_wt) mem[bus.mem_addr] <= bus.mem_wdata;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Strobe legality on both controllers, every cycle out of reset.
  always @(negedge clk) begin
    if (rst_n) begin
      check("strobe_excl",  32'(bus.mem_rd & bus.mem_wt), 0);
      check("strobe_no_cs", 32'((bus.mem_rd | bus.mem_wt) & ~bus.mem_cs), 0);
      check("strobe3_excl", 32'(bus3.mem_rd & bus3.mem_wt), 0);
      check("strobe3_no_cs", 32'((bus3.mem_rd | bus3.mem_wt) & ~bus3.mem_cs), 0);
    end
  end

  // One transaction on dut, checked cycle by cycle against the fixed timeline:
  // cycle 1 SETUP, 2..1+W ACCESS, 2+W HOLD, 3+W back in IDLE.
  task automatic do_txn(input vec_t v, input string tag);
    int         g;
    logic [4:0] got;
    logic [4:0] exp;
    g = 0;
    while (!bus.req_ready && g < 50) begin
      tick();
      g++;
    end
    check({tag, "_ready"}, 32'(bus.req_ready), 1);
    bus.req_valid = 1'b1;
    bus.req_wr    = v.wr;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    tick();
    bus.req_valid  = 1'b0;
    bus.fill_start = 1'b0;
    for (int k = 1; k <= 3 + W; k++) begin
      exp = {k <= 2 + W,
             !v.wr && k >= 2 && k <= 1 + W,
             v.wr && k >= 2 && k <= 1 + W,
             k == 2 + W,
             k == 3 + W};
      got = {bus.mem_cs, bus.mem_rd, bus.mem_wt, bus.rsp_valid, bus.req_ready};
      check($sformatf("%s_c%0d_cs_rd_wt_rv_rdy", tag, k), 32'(got), 32'(exp));
      if (k <= 2 + W) begin
        check($sformatf("%s_c%0d_addr", tag, k), 32'(bus.mem_addr), 32'(v.addr));
        if (v.wr) check($sformatf("%s_c%0d_wdata", tag, k), 32'(bus.mem_wdata), 32'(v.wdata));
      end
      if (k == 2 + W) check($sformatf("%s_rdata", tag), 32'(bus.rsp_rdata), 32'(v.rdata));
      if (k < 3 + W) tick();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=running required=finished");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[10];
    vec_t v;
    int   acc[4];
    int   n_acc;
    int   t;
    int   cnt;
    logic seen;
    logic accepted;

    vecs[0] = '{1'b1, 10'd5,    8'hA5, 8'h00};
    vecs[1] = '{1'b1, 10'd10,   8'h3C, 8'h00};
    vecs[2] = '{1'b1, 10'd1023, 8'hFF, 8'h00};
    vecs[3] = '{1'b1, 10'd0,    8'h01, 8'h00};
    vecs[4] = '{1'b0, 10'd5,    8'h00, 8'hA5};
    vecs[5] = '{1'b0, 10'd1023, 8'h00, 8'hFF};
    vecs[6] = '{1'b0, 10'd10,   8'h00, 8'h3C};
    vecs[7] = '{1'b0, 10'd0,    8'h00, 8'h01};
    vecs[8] = '{1'b1, 10'd6,    8'h5A, 8'h01};
    vecs[9] = '{1'b0, 10'd6,    8'h00, 8'h5A};

    // NOTE: stimulus is driven with blocking assignments 1 time unit after
    // the clock edge, well clear of the DUT's sampling edge.
    rst_n = 1'b0;
    bus.req_valid = 1'b0;  bus.req_wr = 1'b0;  bus.req_addr = '0;
    bus.req_wdata = '0;    bus.fill_start = 1'b0;
    bus3.req_valid = 1'b0; bus3.req_wr = 1'b0; bus3.req_addr = '0;
    bus3.req_wdata = '0;   bus3.fill_start = 1'b0;

    // Reset state
    #12;
    check("rst_outputs",
          32'({bus.req_ready, bus.rsp_valid, bus.mem_cs, bus.mem_rd, bus.mem_wt, bus.fill_busy}), 0);
    check("rst_rdata", 32'(bus.rsp_rdata), 0);
    check("rst_addr",  32'(bus.mem_addr), 0);
    check("rst_wdata", 32'(bus.mem_wdata), 0);
    #10 rst_n = 1'b1;
    tick();
    check("post_rst_ready",  32'(bus.req_ready), 1);
    check("post_rst_ready3", 32'(bus3.req_ready), 1);

    // Table-driven single transactions
    for (int i = 0; i < 10; i++) do_txn(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back: req_valid held high for 4 writes
    n_acc = 0;
    t = 0;
    bus.req_valid = 1'b1; bus.req_wr = 1'b1;
    bus.req_addr = 10'd100; bus.req_wdata = 8'h10;
    while (n_acc < 4 && t < 40) begin
      accepted = bus.req_ready;
      tick();
      t++;
      if (accepted) begin
        acc[n_acc] = t - 1;
        n_acc++;
        if (n_acc < 4) begin
          bus.req_addr  = AW'(100 + n_acc);
          bus.req_wdata = DW'(8'h10 + n_acc);
        end else begin
          bus.req_valid = 1'b0;
        end
      end
    end
    check("b2b_count", 32'(n_acc), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("b2b_accept%0d", i), 32'(acc[i]), 32'(4 * i));
    do_txn('{1'b0, 10'd103, 8'h00, 8'h13}, "b2b_rdback");

    // WAIT_CYCLES=3 read: rsp_valid at cycle 5, three cycles of mem_rd
    check("w3_ready", 32'(bus3.req_ready), 1);
    bus3.req_valid = 1'b1; bus3.req_wr = 1'b0; bus3.req_addr = 10'd5;
    tick();
    bus3.req_valid = 1'b0;
    t = 1;
    cnt = 0;
    while (!bus3.rsp_valid && t < 20) begin
      if (bus3.mem_rd) cnt++;
      tick();
      t++;
    end
    check("w3_rsp_cycle", 32'(t), 5);
    check("w3_rd_cycles", 32'(cnt), 3);
    check("w3_rdata", 32'(bus3.rsp_rdata), 32'h0A5);
    tick();
    check("w3_rv_pulse", 32'(bus3.rsp_valid), 0);

    // Reset during a write's ACCESS cycle
    wait_ready: begin
      bus.req_valid = 1'b1; bus.req_wr = 1'b1;
      bus.req_addr = 10'd300; bus.req_wdata = 8'hC3;
      tick();
      bus.req_valid = 1'b0;
      tick();
      check("rstmid_in_access", 32'({bus.mem_cs, bus.mem_wt}), 32'b11);
      #2 rst_n = 1'b0;
      #1;
      check("rstmid_async_drop",
            32'({bus.mem_cs, bus.mem_wt, bus.mem_rd, bus.rsp_valid, bus.req_ready}), 0);
      @(posedge clk);
      #3 rst_n = 1'b1;
      tick();
      check("rstmid_ready", 32'(bus.req_ready), 1);
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
        seen |= bus.rsp_valid;
        tick();
      end
      check("rstmid_no_rsp", 32'(seen), 0);
      check("rstmid_no_write", 32'(mem[300] === 8'hC3), 0);
    end

`ifdef MEM_CTRL_FILL_EN
    // Full fill: busy for 1024*(3+W) cycles, ready low, no responses
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    cnt = 0;
    seen = 1'b0;
    accepted = 1'b0;
    while (bus.fill_busy && cnt < 6000) begin
      seen |= bus.req_ready;
      accepted |= bus.rsp_valid;
      bus.fill_start = (cnt == 100);   // ignored while busy
      tick();
      cnt++;
    end
    bus.fill_start = 1'b0;
    check("fill_busy_cycles", 32'(cnt), 32'(1024 * (3 + W)));
    check("fill_ready_low", 32'(seen), 0);
    check("fill_no_rsp", 32'(accepted), 0);
    check("fill_mem200", 32'(mem[200]), 144);
    check("fill_mem1023", 32'(mem[1023]), 254);
    check("fill_mem0", 32'(mem[0]), 0);
    cnt = 0;
    for (int k = 0; k < 1024; k++)
      if (mem[k] !== DW'(2 * k)) cnt++;
    check("fill_all_words", 32'(cnt), 0);
    check("fill_done_ready", 32'(bus.req_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= bus.fill_busy;
      tick();
    end
    check("fill_no_restart", 32'(seen), 0);
`else
    // Fill engine absent: a lone fill_start changes nothing
    bus.fill_start = 1'b1;
    tick();
    bus.fill_start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= bus.fill_busy | ~bus.req_ready;
      tick();
    end
    check("nofill_idle", 32'(seen), 0);
`endif

    // Priority: fill_start in the same cycle as a request is dropped
    bus.fill_start = 1'b1;
    do_txn('{1'b1, 10'd7, 8'h77, 8'h00}, "prio");
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      seen |= bus.fill_busy;
      tick();
    end
    check("prio_no_fill", 32'(seen), 0);
    check("prio_written", 32'(mem[7]), 32'h077);
    check("prio_ready", 32'(bus.req_ready), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
